// File: rtl/uart_pkg.sv
// Shared UART types: parity/state enums, data-length encoding and frame config.
// UART_TX_BREAK_EN adds the break/mark states to the TX state enum.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        , ST_BREAK,
        ST_MARK
`endif
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    // Per-frame settings captured when a byte is popped.
    typedef struct packed {
        logic [2:0] last_idx;
        parity_e    parity;
        logic       stop2;
    } tx_cfg_t;

    function automatic logic [3:0] data_bits_count(input logic [1:0] code);
        case (code)
            DBITS_5: return 4'd5;
            DBITS_6: return 4'd6;
            DBITS_7: return 4'd7;
            DBITS_8: return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

    // Code 3 is reserved and falls back to no parity.
    function automatic parity_e parity_decode(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: valid/ready handshake.
interface uart_tx_fifo_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, internal bit-period divider and runtime frame format.
// Define UART_TX_BREAK_EN to add the send_break input (line break plus 2-bit mark).
module uart_tx_fifo import uart_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             send_break,
`endif
    uart_tx_fifo_if.slave    wr,
    output logic             tx_pin,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count
);
    tx_state_e        state;
    tx_cfg_t          cfg_q;
    logic [DIV_W-1:0] div_q, bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;

    logic [7:0] pop_data;
    logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic       bit_end, stop_last, brk;
    logic [3:0] nbits_in;
    parity_e    par_in;
    logic [7:0] data_mask;

`ifdef UART_TX_BREAK_EN
    assign brk = send_break;
`else
    assign brk = 1'b0;
`endif

    assign wr.wr_ready = !fifo_full;
    assign fifo_push   = wr.wr_valid && !fifo_full;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wr.wr_data),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign nbits_in  = data_bits_count(cfg_data_bits);
    assign par_in    = parity_decode(cfg_parity);
    assign data_mask = 8'hFF >> (4'd8 - nbits_in);

    assign bit_end   = (bit_cnt == '0);
    assign stop_last = (state == ST_STOP) && bit_end && (!cfg_q.stop2 || bit_idx == 3'd1);
    // Popping on the final stop clock chains frames with no idle gap.
    assign fifo_pop  = !fifo_empty && !brk && ((state == ST_IDLE) || stop_last);

    always_ff @(posedge clk) begin
        tx_done <= 1'b0;
        if (reset) begin
            state   <= ST_IDLE;
            tx_pin  <= 1'b1;
            tx_busy <= 1'b0;
            cfg_q   <= '0;
            div_q   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        tx_pin  <= shreg[0];
                        bit_idx <= '0;
                        bit_cnt <= div_q;
                    end else bit_cnt <= bit_cnt - DIV_W'(1);
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= div_q;
                        if (bit_idx == cfg_q.last_idx) begin
                            bit_idx <= '0;
                            if (cfg_q.parity != PAR_NONE) begin
                                state  <= ST_PARITY;
                                tx_pin <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                tx_pin <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_pin  <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else bit_cnt <= bit_cnt - DIV_W'(1);
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        tx_pin  <= 1'b1;
                        bit_idx <= '0;
                        bit_cnt <= div_q;
                    end else bit_cnt <= bit_cnt - DIV_W'(1);
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (!stop_last) begin
                            bit_idx <= 3'd1;
                            bit_cnt <= div_q;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else bit_cnt <= bit_cnt - DIV_W'(1);
                end
`ifdef UART_TX_BREAK_EN
                ST_IDLE: begin
                    if (brk) begin
                        state   <= ST_BREAK;
                        tx_pin  <= 1'b0;
                        tx_busy <= 1'b1;
                        div_q   <= baud_div;
                    end
                end
                ST_BREAK: begin
                    if (!brk) begin
                        state   <= ST_MARK;
                        tx_pin  <= 1'b1;
                        bit_idx <= '0;
                        bit_cnt <= div_q;
                    end
                end
                // Two bit periods of mark before the line may start a frame again.
                ST_MARK: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd0) begin
                            bit_idx <= 3'd1;
                            bit_cnt <= div_q;
                        end else begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else bit_cnt <= bit_cnt - DIV_W'(1);
                end
`endif
                default: ;
            endcase

            // Frame start overrides the case above, whether from IDLE or the last stop bit.
            if (fifo_pop) begin
                state   <= ST_START;
                tx_pin  <= 1'b0;
                tx_busy <= 1'b1;
                div_q   <= baud_div;
                bit_cnt <= baud_div;
                shreg   <= pop_data;
                cfg_q   <= '{last_idx: 3'(nbits_in - 4'd1), parity: par_in, stop2: cfg_stop2};
                par_bit <= (^(pop_data & data_mask)) ^ (par_in == PAR_ODD);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue/waveform model checked every cycle plus literal frame checks.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = '0;
    logic [1:0]  cfg_data_bits = '0;
    logic [1:0]  cfg_parity = '0;
    logic        cfg_stop2 = 1'b0;
    logic        tx_pin, tx_busy, tx_done;
    logic [4:0]  fifo_count;

    uart_tx_fifo_if wr_if();

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .send_break    (1'b0),
`endif
        .wr            (wr_if),
        .tx_pin        (tx_pin),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_count    (fifo_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending bytes as a queue, the active frame as a per-clock waveform.
    logic [7:0] mq[$];
    bit         wave[$];
    int         pos;
    bit         active;
    bit         m_pin = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    int         cnt0;

    function automatic void build_wave(input logic [7:0] b);
        int n   = 5 + int'(cfg_data_bits);
        int per = int'(baud_div) + 1;
        bit bits[$];
        bit p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(b[i]);
            p ^= b[i];
        end
        if (cfg_parity == 2'd1) bits.push_back(p);
        else if (cfg_parity == 2'd2) bits.push_back(!p);
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        wave.delete();
        foreach (bits[k]) for (int j = 0; j < per; j++) wave.push_back(bits[k]);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            wave.delete();
            active = 1'b0;
            m_pin  = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            cnt0   = mq.size();
            m_done = 1'b0;
            if (active) begin
                if (pos == wave.size() - 1) begin
                    active = 1'b0;
                    m_done = 1'b1;
                end else pos++;
            end
            if (!active && cnt0 != 0) begin
                build_wave(mq.pop_front());
                active = 1'b1;
                pos    = 0;
            end
            if (wr_if.wr_valid && cnt0 < DEPTH) mq.push_back(wr_if.wr_data);
            m_pin  = active ? wave[pos] : 1'b1;
            m_busy = active;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pin", tx_pin, m_pin);
            chk("busy", tx_busy, m_busy);
            chk("done", tx_done, m_done);
            chk("count", fifo_count, mq.size());
            chk("ready", wr_if.wr_ready, mq.size() < DEPTH);
        end
    end

    // Line monitor for the literal frame checks.
    bit trace[$];
    int busy_cyc, done_cyc, busy_runs;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b0 && tx_busy === 1'b1) begin
            trace.push_back(tx_pin);
            busy_cyc++;
            if (prev_busy !== 1'b1) busy_runs++;
        end
        if (tx_done === 1'b1) done_cyc++;
        prev_busy = tx_busy;
    end

    task automatic clear_mon();
        trace.delete();
        busy_cyc  = 0;
        done_cyc  = 0;
        busy_runs = 0;
    endtask

    function automatic logic [15:0] get_bits(input int nb, input int per);
        logic [15:0] cap = '0;
        for (int k = 0; k < nb; k++)
            cap = {cap[14:0], (k * per < trace.size()) ? trace[k * per] : 1'b1};
        return cap;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = b;
        cyc(1);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] d, input logic [1:0] db, input logic [1:0] par, input logic s2);
        baud_div      = d;
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = s2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(tx_busy === 1'b0 && fifo_count === 5'd0) && n < budget) begin
            cyc(1);
            n++;
        end
        chk("idle_timeout", n < budget, 1);
        cyc(2);
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(2);
        chk("rst_pin", tx_pin, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", wr_if.wr_ready, 1);
        reset = 1'b0;
        cyc(2);

        // 8N1, 4 clk/bit, 0x55, including first-bit latency
        set_cfg(16'd3, 2'd3, 2'd0, 1'b0);
        clear_mon();
        wr_byte(8'h55);
        chk("lat_pin_hi", tx_pin, 1);
        cyc(1);
        chk("lat_pin_lo", tx_pin, 0);
        wait_idle(200);
        chk("f55_bits", get_bits(10, 4), 10'b0101010101);
        chk("f55_busy", busy_cyc, 40);
        chk("f55_done", done_cyc, 1);

        // 7E2, 2 clk/bit, 0x41; config changed mid-frame must not affect it
        set_cfg(16'd1, 2'd2, 2'd1, 1'b1);
        clear_mon();
        wr_byte(8'h41);
        cyc(3);
        set_cfg(16'd7, 2'd0, 2'd2, 1'b0);
        wait_idle(200);
        chk("f41_bits", get_bits(11, 2), 11'b01000001011);
        chk("f41_busy", busy_cyc, 22);
        chk("f41_done", done_cyc, 1);

        // 5O1, 1 clk/bit, 0xFF
        set_cfg(16'd0, 2'd0, 2'd2, 1'b0);
        clear_mon();
        wr_byte(8'hFF);
        wait_idle(100);
        chk("fff_bits", get_bits(8, 1), 8'b01111101);
        chk("fff_busy", busy_cyc, 8);

        // FIFO full: 18 consecutive writes while the first frame is on the line
        set_cfg(16'd20, 2'd3, 2'd0, 1'b0);
        clear_mon();
        for (int i = 0; i < 18; i++) wr_byte(8'(i + 8'h10));
        chk("full_count", fifo_count, 16);
        chk("full_ready", wr_if.wr_ready, 0);
        begin
            int n = 0;
            while (tx_done !== 1'b1 && n < 400) begin
                cyc(1);
                n++;
            end
            chk("full_done_timeout", n < 400, 1);
        end
        chk("pop_count", fifo_count, 15);
        chk("pop_ready", wr_if.wr_ready, 1);
        wait_idle(4000);
        chk("full_frames", done_cyc, 17);

        // Back-to-back 8N1 frames
        set_cfg(16'd3, 2'd3, 2'd0, 1'b0);
        clear_mon();
        wr_byte(8'hA1);
        wr_byte(8'hB2);
        wr_byte(8'hC3);
        wait_idle(400);
        chk("b2b_busy", busy_cyc, 120);
        chk("b2b_runs", busy_runs, 1);
        chk("b2b_done", done_cyc, 3);
        chk("b2b_first", get_bits(10, 4), 10'b0100001011);

        // Reset during data bit 4 with three bytes queued
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        wr_byte(8'h44);
        cyc(19);
        chk("pre_rst_count", fifo_count, 3);
        clear_mon();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mrst_pin", tx_pin, 1);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_busy", tx_busy, 0);
        chk("mrst_done", tx_done, 0);
        cyc(3);
        chk("mrst_no_done", done_cyc, 0);
        wr_byte(8'h3C);
        wait_idle(200);
        chk("post_bits", get_bits(10, 4), 10'b0001111001);
        chk("post_done", done_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
